// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   N-channel arbiter in front of a single-port synchronous memory. Channels
//   present read/write requests with a valid/ready handshake. One transaction
//   is in flight at a time: the granted request is latched, the memory is
//   pulsed once, the arbiter waits MEM_LAT cycles for read data, then returns
//   a one-cycle completion pulse to the owning channel.
//
//   Arbitration is round-robin (search starts after the last granted channel).
//   Define MEM_ARB_FIXED_PRIO_EN to use fixed priority instead (lowest valid
//   index always wins; higher channels can starve).
//
// Ports
//   clk        system clock, all state on rising edge
//   rst        asynchronous, active-high reset
//   req_valid  per-channel request valid
//   req_ready  per-channel accept (one-hot or zero, only while idle)
//   req_we     per-channel 1=write, 0=read
//   req_addr   packed addresses, channel i at [i*ADDR_W +: ADDR_W]
//   req_wdata  packed write data, channel i at [i*DATA_W +: DATA_W]
//   rsp_valid  one-cycle completion pulse to the owning channel
//   rsp_rdata  read data (0 for writes), held until the next capture
//   mem_ce     memory chip enable, one-cycle pulse per transaction
//   mem_wre    memory write enable, only high together with mem_ce
//   mem_ad     memory address (latched request address)
//   mem_din    memory write data (latched request data)
//   mem_dout   memory read data, valid MEM_LAT cycles after mem_ce
//   busy       high whenever a transaction is in flight
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req_valid,
  output logic [NUM_CH-1:0]        req_ready,
  input  logic [NUM_CH-1:0]        req_we,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*DATA_W-1:0] req_wdata,
  output logic [NUM_CH-1:0]        rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     mem_ce,
  output logic                     mem_wre,
  output logic [ADDR_W-1:0]        mem_ad,
  output logic [DATA_W-1:0]        mem_din,
  input  logic [DATA_W-1:0]        mem_dout,
  output logic                     busy
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t              state_q;
  logic [CH_W-1:0]     gnt_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                we_q;
  logic                ce_q;
  logic                wre_q;
  logic [ADDR_W-1:0]   ad_q;
  logic [DATA_W-1:0]   din_q;
  logic [NUM_CH-1:0]   rsp_valid_q;
  logic [DATA_W-1:0]   rdata_q;

  logic [CH_W-1:0]     pick;
  logic                pick_ok;

`ifndef MEM_ARB_FIXED_PRIO_EN
  logic [CH_W-1:0]     last_q;
  int                  cand;
`endif

  // Grant selection. Loops run from the least preferred candidate to the most
  // preferred one so that the last match written is the winner.
  always_comb begin
    // NOTE: every variable gets a default before any condition, otherwise
    // paths that do not assign it would infer a latch.
    pick_ok = 1'b0;
    pick    = '0;
`ifdef MEM_ARB_FIXED_PRIO_EN
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        pick_ok = 1'b1;
        pick    = CH_W'(i);
      end
    end
`else
    cand = 0;
    for (int k = NUM_CH; k >= 1; k--) begin
      cand = (int'(last_q) + k) % NUM_CH;
      if (req_valid[cand]) begin
        pick_ok = 1'b1;
        pick    = CH_W'(cand);
      end
    end
`endif
  end

  // Ready is combinational so a request is accepted in the cycle it is seen.
  assign req_ready = (state_q == S_IDLE && pick_ok) ? (NUM_CH'(1) << pick) : '0;

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= S_IDLE;
      gnt_q       <= '0;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      ce_q        <= 1'b0;
      wre_q       <= 1'b0;
      ad_q        <= '0;
      din_q       <= '0;
      rsp_valid_q <= '0;
      rdata_q     <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      last_q      <= CH_W'(NUM_CH - 1);  // channel 0 wins first
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pick_ok) begin
            gnt_q   <= pick;
            we_q    <= req_we[pick];
            ad_q    <= req_addr[pick*ADDR_W +: ADDR_W];
            din_q   <= req_wdata[pick*DATA_W +: DATA_W];
            // ce/wre are raised here so they are high exactly in ISSUE.
            ce_q    <= 1'b1;
            wre_q   <= req_we[pick];
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_q  <= pick;
`endif
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          ce_q    <= 1'b0;
          wre_q   <= 1'b0;
          cnt_q   <= CNT_W'(MEM_LAT);
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            rdata_q     <= we_q ? '0 : mem_dout;
            rsp_valid_q <= NUM_CH'(1) << gnt_q;
            state_q     <= S_RESP;
          end
        end
        S_RESP: begin
          rsp_valid_q <= '0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign mem_ce    = ce_q;
  assign mem_wre   = wre_q;
  assign mem_ad    = ad_q;
  assign mem_din   = din_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Randomized bench for mem_arbiter (3 channels, 2-cycle memory latency).
//   A transaction-level reference model predicts grants, memory pin activity
//   and responses from the handshake rules; expected responses go into a
//   scoreboard queue that a monitor drains when the DUT pulses rsp_valid.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int NUM_CH  = 3;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;
  localparam int MEM_LAT = 2;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic [NUM_CH-1:0]        req_valid = '0;
  logic [NUM_CH-1:0]        req_ready;
  logic [NUM_CH-1:0]        req_we = '0;
  logic [NUM_CH*ADDR_W-1:0] req_addr = '0;
  logic [NUM_CH*DATA_W-1:0] req_wdata = '0;
  logic [NUM_CH-1:0]        rsp_valid;
  logic [DATA_W-1:0]        rsp_rdata;
  logic                     mem_ce;
  logic                     mem_wre;
  logic [ADDR_W-1:0]        mem_ad;
  logic [DATA_W-1:0]        mem_din;
  logic [DATA_W-1:0]        mem_dout;
  logic                     busy;

  always #5 clk = ~clk;

  mem_arbiter #(
    .NUM_CH (NUM_CH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .MEM_LAT(MEM_LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .mem_ce   (mem_ce),
    .mem_wre  (mem_wre),
    .mem_ad   (mem_ad),
    .mem_din  (mem_din),
    .mem_dout (mem_dout),
    .busy     (busy)
  );

  // ---------------------------------------------------------------------------
  // Environment memory: synchronous, read data appears MEM_LAT cycles after
  // mem_ce and is garbage otherwise, so mistimed capture shows up.
  // ---------------------------------------------------------------------------
  function automatic logic [DATA_W-1:0] init_val(int a);
    return 32'hA5C3_0000 ^ (32'(a) * 32'h0101_0107);
  endfunction

  logic [DATA_W-1:0] mem [256];
  bit                wr_seen [256];
  logic [DATA_W-1:0] rd_pipe [MEM_LAT];

  assign mem_dout = rd_pipe[MEM_LAT-1];

  always @(posedge clk) begin
    if (mem_ce && mem_wre) begin
      mem[mem_ad]     <= mem_din;
      wr_seen[mem_ad] <= 1'b1;
    end
    rd_pipe[0] <= (mem_ce && !mem_wre)
                  ? (wr_seen[mem_ad] ? mem[mem_ad] : init_val(int'(mem_ad)))
                  : 32'hBAD0_BAD0;
    for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  // ---------------------------------------------------------------------------
  // Checking infrastructure
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: which channel wins, expressed directly as a search order.
  // ---------------------------------------------------------------------------
  function automatic int pick(logic [NUM_CH-1:0] v, int last);
`ifdef MEM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NUM_CH; i++) if (v[i]) return i;
`else
    for (int k = 1; k <= NUM_CH; k++) if (v[(last + k) % NUM_CH]) return (last + k) % NUM_CH;
`endif
    return 0;
  endfunction

  typedef struct {
    int                ch;
    logic [DATA_W-1:0] data;
    int                due;
  } rsp_t;

  rsp_t              sb[$];
  logic [DATA_W-1:0] ref_mem [int];

  int                next_ok = 0;      // earliest cycle a new accept can happen
  int                acc_cyc = -100;   // cycle of the most recent accept
  int                m_last  = NUM_CH - 1;
  logic              m_we    = 1'b0;
  logic [ADDR_W-1:0] m_ad    = '0;
  logic [DATA_W-1:0] m_din   = '0;
  logic [DATA_W-1:0] m_rdata = '0;
  logic [NUM_CH-1:0] acc_vec = '0;

  // Monitor + model, sampled on the falling edge (mid-cycle).
  always @(negedge clk) begin
    logic [NUM_CH-1:0] exp_ready;
    logic              exp_ce;
    logic [DATA_W-1:0] d;
    int                g;
    rsp_t              e;
    cyc++;
    if (rst) begin
      check("rst_ctl",  {req_ready, rsp_valid, mem_ce, mem_wre, busy}, '0);
      check("rst_data", {rsp_rdata, mem_din}, '0);
      check("rst_ad",   mem_ad, '0);
      sb.delete();
      next_ok = 0;
      acc_cyc = -100;
      m_last  = NUM_CH - 1;
      m_we    = 1'b0;
      m_rdata = '0;
      acc_vec = '0;
    end else begin
      // Memory pins: one ce pulse the cycle after accept, latched address held.
      exp_ce = (cyc == acc_cyc + 1);
      check("mem_ce",  mem_ce, exp_ce);
      check("mem_wre", mem_wre, exp_ce && m_we);
      if (cyc > acc_cyc && cyc <= acc_cyc + 1 + MEM_LAT) begin
        check("mem_ad",  mem_ad, m_ad);
        check("mem_din", mem_din, m_din);
      end
      check("busy", busy, (cyc > acc_cyc) && (cyc < acc_cyc + 3 + MEM_LAT));

      // Responses.
      if (rsp_valid != '0) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", rsp_valid, '0);
        end else begin
          e = sb.pop_front();
          check("rsp_valid", rsp_valid, NUM_CH'(1) << e.ch);
          check("rsp_cycle", cyc, e.due);
          check("rsp_rdata", rsp_rdata, e.data);
          m_rdata = e.data;
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        check("rsp_valid", rsp_valid, NUM_CH'(1) << e.ch);
        m_rdata = e.data;
      end
      check("rsp_rdata_hold", rsp_rdata, m_rdata);

      // Arbitration for this cycle.
      exp_ready = '0;
      g = 0;
      if (cyc >= next_ok && req_valid != '0) begin
        g = pick(req_valid, m_last);
        exp_ready[g] = 1'b1;
      end
      check("req_ready", req_ready, exp_ready);
      acc_vec = req_valid & req_ready;

      if (exp_ready != '0) begin
        acc_cyc = cyc;
        next_ok = cyc + 3 + MEM_LAT;
        m_last  = g;
        m_we    = req_we[g];
        m_ad    = req_addr[g*ADDR_W +: ADDR_W];
        m_din   = req_wdata[g*DATA_W +: DATA_W];
        if (m_we) begin
          ref_mem[int'(m_ad)] = m_din;
          d = '0;
        end else begin
          d = ref_mem.exists(int'(m_ad)) ? ref_mem[int'(m_ad)] : init_val(int'(m_ad));
        end
        sb.push_back('{ch: g, data: d, due: cyc + 2 + MEM_LAT});
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic new_payload(input int i);
    req_we[i]                    = 1'($urandom % 2);
    req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom % 8);  // small range: lots of RAW hits
    req_wdata[i*DATA_W +: DATA_W] = $urandom;
  endtask

  // One cycle of channel behaviour: accepted channels may re-request, pending
  // ones hold (or occasionally withdraw), idle ones may raise a new request.
  // Idle channels scramble their payload to prove the latched copy is used.
  task automatic step(input int p_raise, input bit allow_drop);
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (acc_vec[i]) begin
        new_payload(i);
        req_valid[i] = ($urandom % 100) < p_raise;
      end else if (req_valid[i]) begin
        if (allow_drop && ($urandom % 16) == 0) req_valid[i] = 1'b0;
      end else begin
        new_payload(i);
        req_valid[i] = ($urandom % 100) < p_raise;
      end
    end
  endtask

  initial begin
    int t;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Mixed random traffic, then all channels hammering continuously.
    repeat (600) step(40, 1'b1);
    repeat (60)  step(100, 1'b0);

    @(posedge clk);
    #1 req_valid = '0;
    repeat (10) @(posedge clk);

    // Abort a read while it waits on the memory.
    #1;
    req_valid                     = 3'b100;
    req_we[2]                     = 1'b0;
    req_addr[2*ADDR_W +: ADDR_W]  = 8'h05;
    t = 0;
    do begin
      @(posedge clk);
      #1;
      t++;
    end while (!acc_vec[2] && t < 20);
    check("abort_accepted", acc_vec[2], 1'b1);
    req_valid = '0;
    @(posedge clk);  // now in the first WAIT cycle
    #3;
    rst = 1'b1;
    #1;
    check("abort_ctl",  {req_ready, rsp_valid, mem_ce, mem_wre, busy}, '0);
    check("abort_data", {rsp_rdata, mem_din}, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // After reset channel 0 must win even though channel 2 was granted last.
    req_valid = '1;
    #1;
    check("post_rst_grant", req_ready, 3'b001);
    repeat (40) step(100, 1'b0);
    @(posedge clk);
    #1 req_valid = '0;

    repeat (3 * (MEM_LAT + 4)) @(posedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
